// File: rtl/floor_request_scheduler.sv
// SCAN floor request scheduler: synchronises and debounces call buttons, latches pending
// requests, selects the next target floor and times the door dwell at each served floor.
module floor_request_scheduler #(
    parameter int NUM_FLOORS      = 10,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int DWELL_CYCLES    = 5000000
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [NUM_FLOORS-1:0] call_btn,
    input  logic [3:0]            current_floor,
    input  logic                  idle,
    output logic [3:0]            requested_floor,
    output logic [NUM_FLOORS-1:0] pending,
    output logic                  door_open,
    output logic                  dir_up
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SERVE = 2'd1,
        S_DOOR  = 2'd2
    } state_t;

    state_t                  state_q, state_d;
    logic [NUM_FLOORS-1:0]   sync1_q, sync2_q, stable_q, stable_d, prev_q, prev_d;
    logic [NUM_FLOORS-1:0]   pending_q, pending_d;
    logic [15:0]             deb_cnt_q, deb_cnt_d;
    logic [23:0]             dwell_q, dwell_d;
    logic                    tick_dly_q;
    logic [3:0]              req_q, req_d;
    logic                    door_q, door_d, dir_up_q, dir_up_d;

    logic                    tick_s, cf_valid_s, up_found_s, down_found_s, dir_next_s;
    logic [3:0]              up_idx_s, down_idx_s, target_s;
    logic [NUM_FLOORS-1:0]   cand_s, cf_onehot_s, set_s, clr_s;

    // Input conditioning: debounce tick and one-shot set pulse after each stable rising edge
    always_comb begin
        tick_s    = (deb_cnt_q == 16'(DEBOUNCE_CYCLES - 1));
        deb_cnt_d = tick_s ? 16'd0 : deb_cnt_q + 16'd1;
        stable_d  = tick_s ? sync2_q : stable_q;
        prev_d    = tick_s ? stable_q : prev_q;
        if (tick_dly_q) begin
            set_s = stable_q & ~prev_q;
        end else begin
            set_s = '0;
        end
    end

    // SCAN target selection over pending requests other than the current floor
    always_comb begin
        cf_valid_s   = (current_floor < 4'(NUM_FLOORS));
        cf_onehot_s  = cf_valid_s ? (NUM_FLOORS'(1) << current_floor) : '0;
        cand_s       = pending_q & ~cf_onehot_s;
        up_found_s   = 1'b0;
        up_idx_s     = 4'd0;
        down_found_s = 1'b0;
        down_idx_s   = 4'd0;
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (cand_s[i] && (4'(i) > current_floor)) begin
                up_found_s = 1'b1;
                up_idx_s   = 4'(i);
            end
        end
        for (int i = 0; i < NUM_FLOORS; i++) begin
            if (cand_s[i] && (4'(i) < current_floor)) begin
                down_found_s = 1'b1;
                down_idx_s   = 4'(i);
            end
        end
        target_s   = current_floor;
        dir_next_s = dir_up_q;
        if (dir_up_q) begin
            if (up_found_s) begin
                target_s = up_idx_s;
            end else if (down_found_s) begin
                target_s   = down_idx_s;
                dir_next_s = 1'b0;
            end else begin
                target_s = current_floor;
            end
        end else begin
            if (down_found_s) begin
                target_s = down_idx_s;
            end else if (up_found_s) begin
                target_s   = up_idx_s;
                dir_next_s = 1'b1;
            end else begin
                target_s = current_floor;
            end
        end
    end

    // Scheduler state machine next-state and pending-request bookkeeping
    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        door_d   = door_q;
        dir_up_d = dir_up_q;
        dwell_d  = dwell_q;
        clr_s    = '0;
        case (state_q)
            S_IDLE: begin
                req_d  = current_floor;
                door_d = 1'b0;
                if ((pending_q & cf_onehot_s) != '0) begin
                    state_d = S_DOOR;
                    door_d  = 1'b1;
                    dwell_d = 24'(DWELL_CYCLES - 1);
                    clr_s   = cf_onehot_s;
                end else if (pending_q != '0) begin
                    state_d  = S_SERVE;
                    req_d    = target_s;
                    dir_up_d = dir_next_s;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SERVE: begin
                // Once the car reaches the target, hold it there until it reports idle
                if (current_floor == req_q) begin
                    if (idle) begin
                        state_d = S_DOOR;
                        door_d  = 1'b1;
                        dwell_d = 24'(DWELL_CYCLES - 1);
                        clr_s   = cf_onehot_s;
                        req_d   = current_floor;
                    end else begin
                        req_d = req_q;
                    end
                end else begin
                    req_d    = target_s;
                    dir_up_d = dir_next_s;
                end
            end
            S_DOOR: begin
                req_d = current_floor;
                clr_s = cf_onehot_s;
                if (dwell_q == 24'd0) begin
                    door_d  = 1'b0;
                    state_d = S_IDLE;
                end else begin
                    door_d  = 1'b1;
                    dwell_d = dwell_q - 24'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                door_d  = 1'b0;
            end
        endcase
        if (state_q == S_DOOR) begin
            pending_d = (pending_q | set_s) & ~clr_s;
        end else begin
            pending_d = (pending_q & ~clr_s) | set_s;
        end
    end

    // State, counters, synchroniser and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            sync1_q    <= '0;
            sync2_q    <= '0;
            stable_q   <= '0;
            prev_q     <= '0;
            pending_q  <= '0;
            deb_cnt_q  <= 16'd0;
            dwell_q    <= 24'd0;
            tick_dly_q <= 1'b0;
            req_q      <= 4'd0;
            door_q     <= 1'b0;
            dir_up_q   <= 1'b1;
        end else begin
            state_q    <= state_d;
            sync1_q    <= call_btn;
            sync2_q    <= sync1_q;
            stable_q   <= stable_d;
            prev_q     <= prev_d;
            pending_q  <= pending_d;
            deb_cnt_q  <= deb_cnt_d;
            dwell_q    <= dwell_d;
            tick_dly_q <= tick_s;
            req_q      <= req_d;
            door_q     <= door_d;
            dir_up_q   <= dir_up_d;
        end
    end

    assign requested_floor = req_q;
    assign pending         = pending_q;
    assign door_open       = door_q;
    assign dir_up          = dir_up_q;

endmodule

// File: tb/tb_floor_request_scheduler.sv
// Directed self-checking bench for floor_request_scheduler (10 floors, debounce 4, dwell 8).
module tb_floor_request_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [9:0] call_btn = 10'd0;
    logic [3:0] current_floor = 4'd0;
    logic       idle = 1'b1;
    logic [3:0] requested_floor;
    logic [9:0] pending;
    logic       door_open;
    logic       dir_up;

    int checks = 0;
    int errors = 0;

    floor_request_scheduler #(
        .NUM_FLOORS(10),
        .DEBOUNCE_CYCLES(4),
        .DWELL_CYCLES(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .call_btn(call_btn),
        .current_floor(current_floor),
        .idle(idle),
        .requested_floor(requested_floor),
        .pending(pending),
        .door_open(door_open),
        .dir_up(dir_up)
    );

    always #5 clk = ~clk;

    // Inputs are driven and outputs sampled on the falling edge
    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
    endtask

    task automatic wait_req(input logic [3:0] val, input int bound);
        for (int n = 0; n < bound && requested_floor !== val; n++) @(negedge clk);
    endtask

    task automatic wait_door(input logic val, input int bound);
        for (int n = 0; n < bound && door_open !== val; n++) @(negedge clk);
    endtask

    task automatic test_reset();
        call_btn = 10'b00_0010_0100;
        current_floor = 4'd0;
        idle = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        cycles(2);
        checks++; if (pending !== 10'd0) begin errors++; $display("FAIL reset_pending got %b exp %b", pending, 10'd0); end
        checks++; if (requested_floor !== 4'd0) begin errors++; $display("FAIL reset_req got %0d exp 0", requested_floor); end
        checks++; if (door_open !== 1'b0) begin errors++; $display("FAIL reset_door got %b exp 0", door_open); end
        checks++; if (dir_up !== 1'b1) begin errors++; $display("FAIL reset_dir got %b exp 1", dir_up); end
        rst = 1'b0;
        for (int n = 0; n < 8 && pending !== 10'b00_0010_0100; n++) @(negedge clk);
        checks++; if (pending !== 10'b00_0010_0100) begin errors++; $display("FAIL reset_held_pending got %b exp %b", pending, 10'b00_0010_0100); end
        cycles(2);
        checks++; if (requested_floor !== 4'd2) begin errors++; $display("FAIL reset_held_req got %0d exp 2", requested_floor); end
        call_btn = 10'd0;
    endtask

    task automatic test_debounce();
        do_reset();
        call_btn[5] = 1'b1;
        @(negedge clk);
        call_btn[5] = 1'b0;
        cycles(12);
        checks++; if (pending !== 10'd0) begin errors++; $display("FAIL debounce_glitch got %b exp %b", pending, 10'd0); end
        call_btn[5] = 1'b1;
        cycles(12);
        checks++; if (pending[5] !== 1'b1) begin errors++; $display("FAIL debounce_hold got %b exp 1", pending[5]); end
        call_btn = 10'd0;
    endtask

    task automatic test_basic_service();
        int cnt;
        do_reset();
        current_floor = 4'd0;
        idle = 1'b1;
        call_btn[3] = 1'b1;
        wait_req(4'd3, 20);
        checks++; if (requested_floor !== 4'd3) begin errors++; $display("FAIL basic_req got %0d exp 3", requested_floor); end
        checks++; if (dir_up !== 1'b1) begin errors++; $display("FAIL basic_dir got %b exp 1", dir_up); end
        call_btn = 10'd0;
        current_floor = 4'd3;
        wait_door(1'b1, 10);
        cnt = 0;
        while (door_open === 1'b1 && cnt < 20) begin
            cnt++;
            checks++; if (pending[3] !== 1'b0) begin errors++; $display("FAIL basic_dwell_pending got %b exp 0", pending[3]); end
            @(negedge clk);
        end
        checks++; if (cnt != 8) begin errors++; $display("FAIL basic_dwell_len got %0d exp 8", cnt); end
        cycles(2);
        checks++; if (requested_floor !== 4'd3) begin errors++; $display("FAIL basic_after_req got %0d exp 3", requested_floor); end
        checks++; if (door_open !== 1'b0 || pending !== 10'd0) begin errors++; $display("FAIL basic_after_idle got door=%b pend=%b exp door=0 pend=0", door_open, pending); end
    endtask

    task automatic test_scan_order();
        do_reset();
        current_floor = 4'd4;
        idle = 1'b1;
        call_btn = 10'b00_1000_0100;
        wait_req(4'd7, 20);
        checks++; if (requested_floor !== 4'd7) begin errors++; $display("FAIL scan_first got %0d exp 7", requested_floor); end
        checks++; if (dir_up !== 1'b1) begin errors++; $display("FAIL scan_first_dir got %b exp 1", dir_up); end
        call_btn = 10'd0;
        current_floor = 4'd7;
        wait_door(1'b1, 10);
        wait_door(1'b0, 20);
        wait_req(4'd2, 10);
        checks++; if (requested_floor !== 4'd2) begin errors++; $display("FAIL scan_reverse got %0d exp 2", requested_floor); end
        checks++; if (dir_up !== 1'b0 || pending !== 10'b00_0000_0100) begin errors++; $display("FAIL scan_reverse_state got dir=%b pend=%b exp dir=0 pend=%b", dir_up, pending, 10'b00_0000_0100); end
        current_floor = 4'd5;
        idle = 1'b0;
        call_btn[6] = 1'b1;
        cycles(14);
        checks++; if (pending !== 10'b00_0100_0100 || requested_floor !== 4'd2) begin errors++; $display("FAIL scan_keep_dir got pend=%b req=%0d exp pend=%b req=2", pending, requested_floor, 10'b00_0100_0100); end
        call_btn = 10'd0;
        idle = 1'b1;
    endtask

    task automatic test_same_floor();
        int bad_req;
        do_reset();
        current_floor = 4'd4;
        idle = 1'b1;
        call_btn[4] = 1'b1;
        for (int n = 0; n < 20 && pending[4] !== 1'b1; n++) @(negedge clk);
        call_btn[4] = 1'b0;
        cycles(3);
        call_btn[4] = 1'b1;
        checks++; if (door_open !== 1'b1) begin errors++; $display("FAIL same_door got %b exp 1", door_open); end
        bad_req = 0;
        for (int n = 0; n < 20 && door_open === 1'b1; n++) begin
            if (requested_floor !== 4'd4) bad_req++;
            @(negedge clk);
        end
        checks++; if (bad_req != 0) begin errors++; $display("FAIL same_req_hold got %0d bad cycles exp 0", bad_req); end
        cycles(4);
        checks++; if (pending[4] !== 1'b0 || door_open !== 1'b0 || requested_floor !== 4'd4) begin errors++; $display("FAIL same_repress got pend4=%b door=%b req=%0d exp 0 0 4", pending[4], door_open, requested_floor); end
        call_btn = 10'd0;
    endtask

    task automatic test_out_of_range();
        do_reset();
        current_floor = 4'd12;
        idle = 1'b1;
        call_btn[3] = 1'b1;
        wait_req(4'd3, 20);
        checks++; if (requested_floor !== 4'd3) begin errors++; $display("FAIL oor_req got %0d exp 3", requested_floor); end
        checks++; if (dir_up !== 1'b0 || pending !== 10'b00_0000_1000) begin errors++; $display("FAIL oor_state got dir=%b pend=%b exp dir=0 pend=%b", dir_up, pending, 10'b00_0000_1000); end
        call_btn = 10'd0;
    endtask

    task automatic test_reset_mid_dwell();
        do_reset();
        current_floor = 4'd1;
        idle = 1'b1;
        call_btn = 10'b01_0000_0010;
        wait_door(1'b1, 20);
        call_btn = 10'd0;
        cycles(2);
        checks++; if (door_open !== 1'b1 || pending !== 10'b01_0000_0000) begin errors++; $display("FAIL middwell_pre got door=%b pend=%b exp door=1 pend=%b", door_open, pending, 10'b01_0000_0000); end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (door_open !== 1'b0) begin errors++; $display("FAIL middwell_door got %b exp 0", door_open); end
        checks++; if (pending !== 10'd0) begin errors++; $display("FAIL middwell_pending got %b exp 0", pending); end
        checks++; if (requested_floor !== 4'd0 || dir_up !== 1'b1) begin errors++; $display("FAIL middwell_out got req=%0d dir=%b exp 0 1", requested_floor, dir_up); end
        cycles(3);
        checks++; if (door_open !== 1'b0 || requested_floor !== 4'd1) begin errors++; $display("FAIL middwell_idle got door=%b req=%0d exp 0 1", door_open, requested_floor); end
    endtask

    initial begin
        test_reset();
        test_debounce();
        test_basic_service();
        test_scan_order();
        test_same_floor();
        test_out_of_range();
        test_reset_mid_dwell();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
